// File: rtl/cache_axi_mem_responder_if.sv
// Cache refill/writeback bus between a cache (master) and its backing memory (slave).
// Carries the read request channel, the read return beats and the write channel.
interface cache_axi_mem_responder_if;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );
endinterface

// File: rtl/cache_axi_mem_responder.sv
// Memory-side responder for the cache refill/writeback bus.
// Serves 4-beat line reads, single-word reads, line writebacks and byte-masked
// word writes from an internal word array, one transaction at a time, with
// programmable read latency, inter-beat gap and write commit latency.
module cache_axi_mem_responder #(
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned BEAT_GAP   = 0,
    parameter int unsigned WR_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    cache_axi_mem_responder_if.slave       bus
);

    localparam int unsigned DEPTH     = 1 << MEM_AW;
    localparam logic [2:0]  LINE_TYPE = 3'b100;

    // Counters hold "cycles remaining after this one", so a wait of N cycles loads N-1.
    localparam logic [3:0] RD_LOAD  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD = 4'(BEAT_GAP - 1);
    localparam logic [3:0] WR_LOAD  = 4'(WR_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RWAIT,
        RBEAT,
        RGAP,
        WBUSY
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [1:0]          beat;

    // Captured read request.
    logic                rd_line;
    logic [MEM_AW-1:0]   rd_idx;

    // Write buffer, held until the commit edge.
    logic                wb_line;
    logic [MEM_AW-1:0]   wb_idx;
    logic [3:0]          wb_strb;
    logic [127:0]        wb_data;

    logic [31:0]         mem [DEPTH];

    logic [MEM_AW-1:0]   rd_ptr;
    logic                is_last_beat;
    logic                commit;

    // Line reads walk the 4 words of the aligned line; the 2-bit beat never leaves it.
    assign rd_ptr       = rd_line ? {rd_idx[MEM_AW-1:2], beat} : rd_idx;
    assign is_last_beat = !rd_line || (beat == 2'd3);
    assign commit       = (state == WBUSY) && (cnt == 4'd0) && !rst;

    // A pending write takes priority, so a read is only offered when no write is asking.
    assign bus.wr_rdy    = (state == IDLE) && !rst;
    assign bus.rd_rdy    = (state == IDLE) && !rst && !bus.wr_req;
    assign bus.ret_valid = (state == RBEAT) && !rst;
    assign bus.ret_last  = bus.ret_valid && is_last_beat;
    assign bus.ret_data  = bus.ret_valid ? mem[rd_ptr] : 32'd0;

    // Transaction FSM: accept, read latency/beat/gap sequencing, write commit timing.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            beat    <= 2'd0;
            rd_line <= 1'b0;
            rd_idx  <= '0;
            wb_line <= 1'b0;
            wb_idx  <= '0;
            wb_strb <= 4'd0;
            wb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_req) begin
                        wb_line <= (bus.wr_type == LINE_TYPE);
                        wb_idx  <= bus.wr_addr[MEM_AW+1:2];
                        wb_strb <= bus.wr_wstrb;
                        wb_data <= bus.wr_data;
                        cnt     <= WR_LOAD;
                        state   <= WBUSY;
                    end else if (bus.rd_req) begin
                        rd_line <= (bus.rd_type == LINE_TYPE);
                        rd_idx  <= bus.rd_addr[MEM_AW+1:2];
                        beat    <= 2'd0;
                        cnt     <= RD_LOAD;
                        state   <= (RD_LATENCY == 0) ? RBEAT : RWAIT;
                    end
                end
                RWAIT: begin
                    if (cnt == 4'd0) state <= RBEAT;
                    else             cnt   <= cnt - 4'd1;
                end
                RBEAT: begin
                    if (is_last_beat) begin
                        state <= IDLE;
                    end else if (BEAT_GAP == 0) begin
                        beat  <= beat + 2'd1;
                    end else begin
                        cnt   <= GAP_LOAD;
                        state <= RGAP;
                    end
                end
                RGAP: begin
                    if (cnt == 4'd0) begin
                        beat  <= beat + 2'd1;
                        state <= RBEAT;
                    end else begin
                        cnt   <= cnt - 4'd1;
                    end
                end
                WBUSY: begin
                    if (cnt == 4'd0) state <= IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array commit: whole line in one edge, or a byte-merged single word.
    // NOTE: the array is deliberately left out of reset; contents survive rst and
    // a write abandoned by rst never reaches this block because commit is gated.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (wb_line) begin
                for (int i = 0; i < 4; i++) begin
                    mem[{wb_idx[MEM_AW-1:2], 2'(i)}] <= wb_data[32*i +: 32];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_strb[b]) mem[wb_idx][8*b +: 8] <= wb_data[8*b +: 8];
                end
            end
        end
    end

endmodule
